// File: rtl/video_fx_pkg.sv
// Shared types and arithmetic helpers for the scanline output stage.
package video_fx_pkg;

    localparam int SL_LVL_W = 3;
    localparam int SL_GRP_W = 2;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb8_t;

    function automatic logic [7:0] sl_atten(
        input logic [7:0]          c8,
        input logic [SL_LVL_W-1:0] lvl
    );
        logic [10:0] p;
        p = {3'b000, c8} * {8'h00, lvl};
        return c8 - p[10:3];
    endfunction

    // c holds a right-aligned cw-bit value; MSBs are replicated into the low bits.
    function automatic logic [7:0] expand_cw(
        input logic [7:0] c,
        input int         cw
    );
        logic [7:0] o;
        logic [2:0] idx;
        o = '0;
        for (int i = 0; i < 8; i++) begin
            idx = 3'((cw - 1) - (i % cw));
            o   = {o[6:0], c[idx]};
        end
        return o;
    endfunction

endpackage

// File: rtl/video_sl_line_tracker.sv
// Sync edge detection, line/field counting and the per-line dim decision.
module video_sl_line_tracker
    import video_fx_pkg::*;
#(
    parameter bit ALT_EN = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ce,
    input  logic                hs,
    input  logic                vs,
    input  logic [SL_LVL_W-1:0] sl_level,
    input  logic [SL_GRP_W-1:0] sl_group,
    input  logic                sl_alt,
    output logic                dim,
    output logic [SL_LVL_W-1:0] lvl
);

    logic                hs_q, hs_d;
    logic                vs_q, vs_d;
    logic [2:0]          cnt_q, cnt_d;
    logic                field_q, field_d;
    logic [SL_LVL_W-1:0] lvl_q, lvl_d;
    logic [SL_GRP_W-1:0] grp_q, grp_d;
    logic [2:0]          gm1_new, gm1_cur, dim_idx;

    always_comb begin
        hs_d    = hs_q;
        vs_d    = vs_q;
        cnt_d   = cnt_q;
        field_d = field_q;
        lvl_d   = lvl_q;
        grp_d   = grp_q;
        gm1_new = {1'b0, sl_group} + 3'd1;
        gm1_cur = {1'b0, grp_q} + 3'd1;
        if (ce) begin
            hs_d = hs;
            vs_d = vs;
            // >= also wraps a count left stranded by a shrinking group
            if (hs_q && !hs) begin
                lvl_d = sl_level;
                grp_d = sl_group;
                cnt_d = (cnt_q >= gm1_new) ? 3'd0 : cnt_q + 3'd1;
            end
            if (vs_q && !vs) begin
                cnt_d   = 3'd0;
                field_d = ALT_EN ? ~field_q : 1'b0;
            end
        end
        dim_idx = (sl_alt && field_q) ? 3'd0 : gm1_cur;
        dim     = (lvl_q != '0) && (cnt_q == dim_idx);
        lvl     = lvl_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hs_q    <= 1'b0;
            vs_q    <= 1'b0;
            cnt_q   <= 3'd0;
            field_q <= 1'b0;
            lvl_q   <= '0;
            grp_q   <= '0;
        end else begin
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            cnt_q   <= cnt_d;
            field_q <= field_d;
            lvl_q   <= lvl_d;
            grp_q   <= grp_d;
        end
    end

endmodule

// File: rtl/video_scanline_fx.sv
// Scanline/dimming output stage: expand, attenuate, derive DE, two-stage register.
module video_scanline_fx
    import video_fx_pkg::*;
#(
    parameter int CW     = 8,
    parameter bit ALT_EN = 1'b1
) (
    input  logic                clk_vid,
    input  logic                reset,
    input  logic                ce_pix,
    input  logic [CW-1:0]       R,
    input  logic [CW-1:0]       G,
    input  logic [CW-1:0]       B,
    input  logic                HSync,
    input  logic                VSync,
    input  logic                HBlank,
    input  logic                VBlank,
    input  logic [SL_LVL_W-1:0] sl_level,
    input  logic [SL_GRP_W-1:0] sl_group,
    input  logic                sl_alt,
    output logic [7:0]          VGA_R,
    output logic [7:0]          VGA_G,
    output logic [7:0]          VGA_B,
    output logic                VGA_HS,
    output logic                VGA_VS,
    output logic                VGA_DE
);

    logic                dim;
    logic [SL_LVL_W-1:0] lvl;
    rgb8_t               c8, att;
    logic                hde, de_next;

    rgb8_t v_q, v_d, o_q, o_d;
    logic  hde_q, hde_d, de_int_q, de_int_d;
    logic  hs1_q, hs1_d, vs1_q, vs1_d, de1_q, de1_d;
    logic  hs2_q, hs2_d, vs2_q, vs2_d, de2_q, de2_d;

    video_sl_line_tracker #(
        .ALT_EN(ALT_EN)
    ) u_trk (
        .clk     (clk_vid),
        .reset   (reset),
        .ce      (ce_pix),
        .hs      (HSync),
        .vs      (VSync),
        .sl_level(sl_level),
        .sl_group(sl_group),
        .sl_alt  (sl_alt),
        .dim     (dim),
        .lvl     (lvl)
    );

    always_comb begin
        c8.r  = expand_cw(8'(R), CW);
        c8.g  = expand_cw(8'(G), CW);
        c8.b  = expand_cw(8'(B), CW);
        att   = c8;
        if (dim) begin
            att.r = sl_atten(c8.r, lvl);
            att.g = sl_atten(c8.g, lvl);
            att.b = sl_atten(c8.b, lvl);
        end
        hde     = ~HBlank;
        de_next = de_int_q;
        if (hde && !hde_q) begin
            de_next = ~VBlank;
        end else if (!hde && hde_q) begin
            de_next = 1'b0;
        end
        hde_d    = hde_q;
        de_int_d = de_int_q;
        v_d      = v_q;
        hs1_d    = hs1_q;
        vs1_d    = vs1_q;
        de1_d    = de1_q;
        o_d      = o_q;
        hs2_d    = hs2_q;
        vs2_d    = vs2_q;
        de2_d    = de2_q;
        // stage 1 takes the updated DE so it lines up with this pixel
        if (ce_pix) begin
            hde_d    = hde;
            de_int_d = de_next;
            v_d      = att;
            hs1_d    = HSync;
            vs1_d    = VSync;
            de1_d    = de_next;
            o_d      = v_q;
            hs2_d    = hs1_q;
            vs2_d    = vs1_q;
            de2_d    = de1_q;
        end
    end

    always_ff @(posedge clk_vid) begin
        if (reset) begin
            hde_q    <= 1'b0;
            de_int_q <= 1'b0;
            v_q      <= '0;
            hs1_q    <= 1'b0;
            vs1_q    <= 1'b0;
            de1_q    <= 1'b0;
            o_q      <= '0;
            hs2_q    <= 1'b0;
            vs2_q    <= 1'b0;
            de2_q    <= 1'b0;
        end else begin
            hde_q    <= hde_d;
            de_int_q <= de_int_d;
            v_q      <= v_d;
            hs1_q    <= hs1_d;
            vs1_q    <= vs1_d;
            de1_q    <= de1_d;
            o_q      <= o_d;
            hs2_q    <= hs2_d;
            vs2_q    <= vs2_d;
            de2_q    <= de2_d;
        end
    end

    assign VGA_R  = o_q.r;
    assign VGA_G  = o_q.g;
    assign VGA_B  = o_q.b;
    assign VGA_HS = hs2_q;
    assign VGA_VS = vs2_q;
    assign VGA_DE = de2_q;

endmodule

// File: tb/tb_video_scanline_fx.sv
// Scoreboard bench for video_scanline_fx (CW=8 and CW=4 instances).
module tb_video_scanline_fx;

    logic       clk_vid = 1'b0;
    logic       reset, ce_pix;
    logic [7:0] R, G, B;
    logic       HSync, VSync, HBlank, VBlank;
    logic [2:0] sl_level;
    logic [1:0] sl_group;
    logic       sl_alt;

    logic [7:0] VGA_R, VGA_G, VGA_B;
    logic       VGA_HS, VGA_VS, VGA_DE;
    logic [7:0] V4_R, V4_G, V4_B;
    logic       V4_HS, V4_VS, V4_DE;

    always #5 clk_vid = ~clk_vid;

    video_scanline_fx #(.CW(8), .ALT_EN(1'b1)) dut (
        .clk_vid(clk_vid), .reset(reset), .ce_pix(ce_pix),
        .R(R), .G(G), .B(B),
        .HSync(HSync), .VSync(VSync), .HBlank(HBlank), .VBlank(VBlank),
        .sl_level(sl_level), .sl_group(sl_group), .sl_alt(sl_alt),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
        .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_DE(VGA_DE)
    );

    video_scanline_fx #(.CW(4), .ALT_EN(1'b1)) dut4 (
        .clk_vid(clk_vid), .reset(reset), .ce_pix(ce_pix),
        .R(R[7:4]), .G(G[7:4]), .B(B[7:4]),
        .HSync(HSync), .VSync(VSync), .HBlank(HBlank), .VBlank(VBlank),
        .sl_level(sl_level), .sl_group(sl_group), .sl_alt(sl_alt),
        .VGA_R(V4_R), .VGA_G(V4_G), .VGA_B(V4_B),
        .VGA_HS(V4_HS), .VGA_VS(V4_VS), .VGA_DE(V4_DE)
    );

    typedef struct {
        logic [26:0] v;
        bit          c4;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   ce_div = 1;
    int   pix_no = 0;
    bit   mon_en = 1'b0;

    function automatic logic [26:0] pk(input logic [7:0] e, input logic hs,
                                       input logic vs, input logic de);
        return {e, e, e, hs, vs, de};
    endfunction

    task automatic cmp(input string nm, input int idx,
                       input logic [26:0] act, input logic [26:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s #%0d: got %h want %h", nm, idx, act, exp);
        end
    endtask

    // monitor: one scoreboard pop per ce_pix edge, hold check otherwise
    initial begin
        logic        ce_s;
        logic [26:0] cur, cur4, prev;
        exp_t        x;
        prev = '0;
        forever begin
            @(posedge clk_vid);
            if (mon_en) begin
                ce_s = ce_pix;
                #1;
                cur  = {VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_DE};
                cur4 = {V4_R, V4_G, V4_B, V4_HS, V4_VS, V4_DE};
                if (ce_s) begin
                    if (q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL underflow #%0d: got empty want entry", pix_no);
                    end else begin
                        x = q.pop_front();
                        cmp("pix", pix_no, cur, x.v);
                        if (x.c4) cmp("pix_cw4", pix_no, cur4, x.v);
                    end
                    pix_no++;
                end else begin
                    cmp("hold", pix_no, cur, prev);
                end
                prev = cur;
            end
        end
    end

    task automatic drive(input logic [7:0] c, input logic hs, input logic vs,
                         input logic hb, input logic vb,
                         input logic [7:0] e, input logic ede);
        exp_t x;
        R = c; G = c; B = c;
        HSync = hs; VSync = vs; HBlank = hb; VBlank = vb;
        ce_pix = 1'b1;
        x.v  = pk(e, hs, vs, ede);
        x.c4 = (c[7:4] == c[3:0]);
        q.push_back(x);
        if (ce_div > 1) begin
            @(negedge clk_vid);
            ce_pix = 1'b0;
            repeat (ce_div - 2) @(negedge clk_vid);
        end
    endtask

    task automatic pix(input logic [7:0] c, input logic hs, input logic vs,
                       input logic hb, input logic vb,
                       input logic [7:0] e, input logic ede);
        @(negedge clk_vid);
        drive(c, hs, vs, hb, vb, e, ede);
    endtask

    // sync pixel, HS falling pixel, then three active pixels
    task automatic line(input logic [7:0] c, input logic [7:0] e,
                        input logic vsf, input logic vb, input logic vbr);
        pix(8'h00, 1'b1, vsf,  1'b1, vb, 8'h00, 1'b0);
        pix(8'h00, 1'b0, 1'b0, 1'b1, vb, 8'h00, 1'b0);
        pix(c, 1'b0, 1'b0, 1'b0, vb, e, ~vb);
        repeat (2) pix(c, 1'b0, 1'b0, 1'b0, vbr, e, ~vb);
    endtask

    initial begin
        exp_t z;
        reset = 1'b1; ce_pix = 1'b1;
        R = 8'hFF; G = 8'hFF; B = 8'hFF;
        HSync = 1'b0; VSync = 1'b0; HBlank = 1'b1; VBlank = 1'b0;
        sl_level = 3'd0; sl_group = 2'd0; sl_alt = 1'b0;

        repeat (3) begin
            @(posedge clk_vid);
            #1;
            cmp("reset", 0, {VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_DE}, '0);
            cmp("reset_cw4", 0, {V4_R, V4_G, V4_B, V4_HS, V4_VS, V4_DE}, '0);
        end

        @(negedge clk_vid);
        reset  = 1'b0;
        mon_en = 1'b1;
        z.v = '0; z.c4 = 1'b1;
        q.push_back(z);
        drive(8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 8'hFF, 1'b0);

        // G=2, lvl 4 on 0xC8: bright 200 / dim 100; VS restarts bright
        sl_level = 3'd4; sl_group = 2'd0; sl_alt = 1'b0;
        line(8'hC8, 8'd200, 1'b1, 1'b0, 1'b0);
        line(8'hC8, 8'd100, 1'b0, 1'b0, 1'b0);
        line(8'hC8, 8'd200, 1'b0, 1'b0, 1'b0);
        line(8'hC8, 8'd200, 1'b1, 1'b0, 1'b0);
        line(8'hC8, 8'd100, 1'b0, 1'b0, 1'b0);

        // G=4, alt, lvl 7: field 1 dims line 0, field 0 dims line 3
        sl_level = 3'd7; sl_group = 2'd2; sl_alt = 1'b1;
        line(8'hFF, 8'd32,  1'b1, 1'b0, 1'b0);
        line(8'hFF, 8'd255, 1'b0, 1'b0, 1'b0);
        line(8'hFF, 8'd255, 1'b0, 1'b0, 1'b0);
        line(8'hFF, 8'd255, 1'b0, 1'b0, 1'b0);
        line(8'hFF, 8'd32,  1'b0, 1'b0, 1'b0);
        line(8'hFF, 8'd255, 1'b1, 1'b0, 1'b0);
        line(8'hFF, 8'd255, 1'b0, 1'b0, 1'b0);
        line(8'hFF, 8'd255, 1'b0, 1'b0, 1'b0);

        // group shrinks to 2 while line_cnt=2: wraps to 0
        sl_group = 2'd0;
        line(8'hFF, 8'd255, 1'b0, 1'b0, 1'b0);
        line(8'hFF, 8'd32,  1'b0, 1'b0, 1'b0);
        line(8'hFF, 8'd255, 1'b0, 1'b0, 1'b0);

        // level 2 -> 6 mid-line: this line stays 192, next dim line 64
        sl_level = 3'd2; sl_alt = 1'b0;
        pix(8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        pix(8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        pix(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 8'd192, 1'b1);
        sl_level = 3'd6;
        repeat (2) pix(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 8'd192, 1'b1);
        line(8'hFF, 8'd255, 1'b0, 1'b0, 1'b0);
        line(8'hFF, 8'd64,  1'b0, 1'b0, 1'b0);

        // expansion: 4'h7 -> 0x77; lvl 1 dims to 105; 4'hA -> 0xAA
        sl_level = 3'd0;
        line(8'h77, 8'h77, 1'b0, 1'b0, 1'b0);
        line(8'h77, 8'h77, 1'b0, 1'b0, 1'b0);
        sl_level = 3'd1;
        line(8'h77, 8'h77, 1'b0, 1'b0, 1'b0);
        line(8'h77, 8'd105, 1'b0, 1'b0, 1'b0);
        line(8'hAA, 8'hAA, 1'b0, 1'b0, 1'b0);

        // VBlank at active start: DE 0 for the whole line
        line(8'hAA, 8'd149, 1'b0, 1'b1, 1'b0);

        // ce_pix every 4th clock
        ce_div = 4;
        line(8'hAA, 8'hAA,  1'b0, 1'b0, 1'b0);
        line(8'hAA, 8'd149, 1'b0, 1'b0, 1'b0);
        ce_div = 1;

        pix(8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        pix(8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        @(negedge clk_vid);
        ce_pix = 1'b0;
        repeat (3) @(posedge clk_vid);
        #2;
        mon_en = 1'b0;
        n_vec++;
        if (q.size() != 1) begin
            n_err++;
            $display("FAIL drain: got %0d queued want 1", q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
